kd_tree_root_ctrl: RTL and testbench
====================================

// Module: kd_tree_root_ctrl
// PURPOSE
//  Sequencer on the top port of the root kd-tree node. Buffers NUM_CENTERS centers from an upstream stream.
//  Drives the command/data protocol in order: rst, center_fill, configure_sort_axis, start_sorting.
//  Waits on each phase's completion reply and reports done/err to the host.
// PARAMETERS
//  NUM_CENTERS   8    centers buffered and streamed per run (1..16)
//  SETTLE_CYCLES 4    consecutive ready_to_sort cycles that count as a settled sort
//  TIMEOUT       1024 per-phase watchdog limit in cycles (only with KD_CTRL_TIMEOUT_EN)
// PORTS
//  clk                in   1   clock
//  rst                in   1   synchronous active-high reset
//  start              in   1   pulse; starts a run (honoured in IDLE/DONE/ERROR only)
//  center_valid       in   1   center stream valid
//  center_ready       out  1   center stream ready (high only in LOAD)
//  center_data        in   24  center {x,y,z} 8b each
//  axis_in            in   2   sort axis for this run, sampled on start
//  command_to_root    out  5   command to root node's command_from_top
//  data_to_root       out  24  data to root node's data_from_top
//  command_from_root  in   5   root node's command_to_top
//  data_from_root     in   24  root node's data_to_top
//  busy               out  1   high in every state except IDLE/DONE/ERROR
//  done               out  1   one-cycle pulse on entry to DONE
//  err                out  1   sticky timeout flag, cleared by start or rst
//  state_out          out  3   current state encoding (debug)
//  root_center        out  24  data_from_root latched when the sort settles
// BEHAVIOUR
//  Command codes: nop 00, rst 1F, rst_done 1E, center_fill 01, center_fill_done 05.
//    configure_sort_axis 02, configure_sort_axis_done 07, busy 08, start_sorting 09, ready_to_sort 0A.
//  Reset values:
//    command_to_root=nop; data_to_root=0; center_ready/busy/done/err=0; root_center=0; state=IDLE(0).
//    Index and counter registers=0. Buffer contents are don't-care.
//  All outputs are registered. Command and data change together on the same clock edge.
//  States and transitions:
//   IDLE(0): drive nop. On start, latch axis_in, clear err, go to TREE_RST.
//   TREE_RST(1): drive rst with data 0 every cycle. On command_from_root==rst_done, go to LOAD.
//   LOAD(2): center_ready=1. Each valid&&ready beat writes buf[wr_idx] and increments wr_idx.
//    Entry to FILL happens after the beat that writes index NUM_CENTERS-1. wr_idx resets to 0.
//   FILL(3): drive center_fill every cycle. data_to_root=buf[rd_idx].
//    rd_idx increments each cycle and saturates at NUM_CENTERS-1, so the last center is held.
//    On center_fill_done, go to AXIS. Early done (rd_idx<NUM_CENTERS-1) is legal and the remaining centers are dropped.
//   AXIS(4): drive configure_sort_axis with data_to_root={22'b0,axis}.
//    On configure_sort_axis_done, go to SORT.
//   SORT(5): drive start_sorting with data_to_root={22'b0,axis}.
//    settle_cnt increments on each ready_to_sort cycle and clears on any other reply (busy included).
//    When settle_cnt reaches SETTLE_CYCLES: latch root_center<=data_from_root, go to DONE.
//   DONE(6): drive nop. done pulses for 1 cycle. start restarts the run at TREE_RST.
//   ERROR(7): drive nop. err=1. Only start or rst leaves this state.
//  Replies are checked only against the current state's expected code. All other codes are ignored.
//  A start pulse while busy is ignored.
//  Reset mid-run: any state returns to IDLE on the next edge. The tree itself is not cleaned until the next run's TREE_RST.
//  Handshake timing: the first command is driven the cycle after the state is entered.
//    A reply seen in the same cycle as the command is accepted; the state advances one edge later.
// CONFIGURATION
//  KD_CTRL_TIMEOUT_EN defined:
//    A 16b phase counter clears on every state change and increments in TREE_RST, FILL, AXIS and SORT.
//    Reaching TIMEOUT sets err and moves to ERROR. LOAD is never timed, since it is upstream-paced.
//  KD_CTRL_TIMEOUT_EN undefined: no counter. Every phase waits indefinitely. err is tied 0 and ERROR is unreachable.
// TESTING
//  1 Reset: rst high for 2 cycles mid-FILL -> state_out=0, command_to_root=00, busy=0 on the next edge.
//  2 Full run, stub tree: rst_done after 3 cycles, 8 centers 0x010203..0x080808, center_fill_done after 10 cycles,
//    axis_done after 2, ready_to_sort steady with data 0x0A0B0C.
//    -> command sequence 1F,01,02,09,00; data_to_root walks buf[0..7] then holds 0x080808.
//    -> done pulses once; root_center=0x0A0B0C.
//  3 Settle interruption: in SORT reply 0A,0A,0A,08,0A x4 -> done fires exactly 4 cycles after the final 08 clears settle_cnt.
//  4 Backpressure in LOAD: valid toggles 1,0,1,... -> all 8 centers captured in order; FILL starts after the 8th beat only.
//  5 Early fill done: center_fill_done at rd_idx=3 -> AXIS entered; data_to_root={22'b0,axis_in}.
//  6 (KD_CTRL_TIMEOUT_EN, TIMEOUT=16) no rst_done reply -> ERROR after 16 cycles with err=1; start clears err and re-enters TREE_RST.

Source files
------------

// File: rtl/kd_tree_root_ctrl.sv
// kd_tree_root_ctrl
// Sequencer on the top port of the root kd-tree node. It buffers NUM_CENTERS
// centers from an upstream stream, then walks the root node through
// rst -> center_fill -> configure_sort_axis -> start_sorting. Each phase waits
// for its completion reply, and the block reports done/err to the host.
// Optional feature: define KD_CTRL_TIMEOUT_EN to add a per-phase watchdog of
// TIMEOUT cycles. When it expires, the sequencer moves to ERROR and raises err.
// Without the macro every phase waits indefinitely and err stays 0.

module kd_tree_root_ctrl #(
  parameter int NUM_CENTERS   = 8,
  parameter int SETTLE_CYCLES = 4
`ifdef KD_CTRL_TIMEOUT_EN
  ,
  parameter int TIMEOUT       = 1024
`endif
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        center_valid,
  output logic        center_ready,
  input  logic [23:0] center_data,
  input  logic [1:0]  axis_in,
  output logic [4:0]  command_to_root,
  output logic [23:0] data_to_root,
  input  logic [4:0]  command_from_root,
  input  logic [23:0] data_from_root,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic [2:0]  state_out,
  output logic [23:0] root_center
);

  localparam int IW = (NUM_CENTERS > 1) ? $clog2(NUM_CENTERS) : 1;
  localparam int SW = $clog2(SETTLE_CYCLES + 1);
  localparam logic [IW-1:0] LAST_IDX    = IW'(NUM_CENTERS - 1);
  localparam logic [SW-1:0] SETTLE_LAST = SW'(SETTLE_CYCLES - 1);

  // Command codes shared with the kd-tree node command port
  localparam logic [4:0] CMD_NOP        = 5'h00;
  localparam logic [4:0] CMD_RST        = 5'h1F;
  localparam logic [4:0] CMD_RST_DONE   = 5'h1E;
  localparam logic [4:0] CMD_FILL       = 5'h01;
  localparam logic [4:0] CMD_FILL_DONE  = 5'h05;
  localparam logic [4:0] CMD_AXIS       = 5'h02;
  localparam logic [4:0] CMD_AXIS_DONE  = 5'h07;
  localparam logic [4:0] CMD_SORT       = 5'h09;
  localparam logic [4:0] CMD_READY      = 5'h0A;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_TREE_RST = 3'd1,
    ST_LOAD     = 3'd2,
    ST_FILL     = 3'd3,
    ST_AXIS     = 3'd4,
    ST_SORT     = 3'd5,
    ST_DONE     = 3'd6,
    ST_ERROR    = 3'd7
  } state_t;

  state_t          state_r;
  state_t          state_nxt_s;
  logic [1:0]      axis_r;
  logic [IW-1:0]   wr_idx_r;
  logic [IW-1:0]   rd_idx_r;
  logic [SW-1:0]   settle_cnt_r;
  logic [23:0]     center_buf_r [NUM_CENTERS];
  logic            beat_s;
  logic            start_ok_s;
  logic            settle_hit_s;
  logic            phase_tmo_s;

  // The host-visible states (IDLE/DONE/ERROR) are the only ones that accept start
  function automatic logic is_busy(input state_t s);
    case (s)
      ST_IDLE, ST_DONE, ST_ERROR: is_busy = 1'b0;
      default:                    is_busy = 1'b1;
    endcase
  endfunction

  assign state_out    = state_r;
  assign beat_s       = center_valid && center_ready && (state_r == ST_LOAD);
  assign start_ok_s   = start && !is_busy(state_r);
  assign settle_hit_s = (state_r == ST_SORT) && (command_from_root == CMD_READY) &&
                        (settle_cnt_r == SETTLE_LAST);

`ifdef KD_CTRL_TIMEOUT_EN
  logic [15:0] phase_cnt_r;
  logic        timed_s;

  // LOAD is paced by the upstream stream, so it is left out of the watchdog
  assign timed_s     = (state_r == ST_TREE_RST) || (state_r == ST_FILL) ||
                       (state_r == ST_AXIS) || (state_r == ST_SORT);
  assign phase_tmo_s = timed_s && (phase_cnt_r == 16'(TIMEOUT - 1));

  // Phase watchdog: restarts on every state change, counts only in timed phases
  always_ff @(posedge clk) begin
    if (rst) begin
      phase_cnt_r <= 16'd0;
    end else if (state_nxt_s != state_r) begin
      phase_cnt_r <= 16'd0;
    end else if (timed_s) begin
      phase_cnt_r <= phase_cnt_r + 16'd1;
    end else begin
      phase_cnt_r <= 16'd0;
    end
  end
`else
  assign phase_tmo_s = 1'b0;
`endif

  // Next-state decode: a reply is only acted on when it is the current phase's completion code
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE, ST_DONE, ST_ERROR: begin
        if (start_ok_s) state_nxt_s = ST_TREE_RST;
        else            state_nxt_s = state_r;
      end
      ST_TREE_RST: begin
        if (command_from_root == CMD_RST_DONE) state_nxt_s = ST_LOAD;
        else if (phase_tmo_s)                  state_nxt_s = ST_ERROR;
        else                                   state_nxt_s = state_r;
      end
      ST_LOAD: begin
        if (beat_s && (wr_idx_r == LAST_IDX)) state_nxt_s = ST_FILL;
        else                                  state_nxt_s = state_r;
      end
      ST_FILL: begin
        if (command_from_root == CMD_FILL_DONE) state_nxt_s = ST_AXIS;
        else if (phase_tmo_s)                   state_nxt_s = ST_ERROR;
        else                                    state_nxt_s = state_r;
      end
      ST_AXIS: begin
        if (command_from_root == CMD_AXIS_DONE) state_nxt_s = ST_SORT;
        else if (phase_tmo_s)                   state_nxt_s = ST_ERROR;
        else                                    state_nxt_s = state_r;
      end
      ST_SORT: begin
        if (settle_hit_s)     state_nxt_s = ST_DONE;
        else if (phase_tmo_s) state_nxt_s = ST_ERROR;
        else                  state_nxt_s = state_r;
      end
      default: state_nxt_s = ST_IDLE;
    endcase
  end

  // Center buffer: written only by accepted LOAD beats, so its contents need no reset
  always_ff @(posedge clk) begin
    if (beat_s) begin
      center_buf_r[wr_idx_r] <= center_data;
    end
  end

  // Sequencer state, indices and registered host/root outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r         <= ST_IDLE;
      command_to_root <= CMD_NOP;
      data_to_root    <= 24'd0;
      center_ready    <= 1'b0;
      busy            <= 1'b0;
      done            <= 1'b0;
      err             <= 1'b0;
      root_center     <= 24'd0;
      axis_r          <= 2'd0;
      wr_idx_r        <= {IW{1'b0}};
      rd_idx_r        <= {IW{1'b0}};
      settle_cnt_r    <= {SW{1'b0}};
    end else begin
      state_r <= state_nxt_s;

      // Status flags track the state being entered so handshakes line up with it
      center_ready <= (state_nxt_s == ST_LOAD);
      busy         <= is_busy(state_nxt_s);
      done         <= (state_nxt_s == ST_DONE) && (state_r != ST_DONE);
`ifdef KD_CTRL_TIMEOUT_EN
      err          <= (state_nxt_s == ST_ERROR);
`else
      err          <= 1'b0;
`endif

      if (start_ok_s) axis_r <= axis_in;

      if (beat_s) begin
        if (wr_idx_r == LAST_IDX) wr_idx_r <= {IW{1'b0}};
        else                      wr_idx_r <= wr_idx_r + IW'(1'b1);
      end else if (start_ok_s) begin
        wr_idx_r <= {IW{1'b0}};
      end

      // rd_idx saturates on the last center so the root keeps seeing it until fill completes
      if (state_r == ST_FILL) begin
        if (rd_idx_r != LAST_IDX) rd_idx_r <= rd_idx_r + IW'(1'b1);
      end else begin
        rd_idx_r <= {IW{1'b0}};
      end

      // Any reply other than ready_to_sort (busy included) breaks the settle streak
      if ((state_r == ST_SORT) && (command_from_root == CMD_READY) && !settle_hit_s) begin
        settle_cnt_r <= settle_cnt_r + SW'(1'b1);
      end else begin
        settle_cnt_r <= {SW{1'b0}};
      end

      if (settle_hit_s) root_center <= data_from_root;

      // Command and data follow the state one cycle later and always change together
      case (state_r)
        ST_TREE_RST: begin
          command_to_root <= CMD_RST;
          data_to_root    <= 24'd0;
        end
        ST_FILL: begin
          command_to_root <= CMD_FILL;
          data_to_root    <= center_buf_r[rd_idx_r];
        end
        ST_AXIS: begin
          command_to_root <= CMD_AXIS;
          data_to_root    <= {22'd0, axis_r};
        end
        ST_SORT: begin
          command_to_root <= CMD_SORT;
          data_to_root    <= {22'd0, axis_r};
        end
        default: begin
          command_to_root <= CMD_NOP;
          data_to_root    <= 24'd0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_kd_tree_root_ctrl.sv
// tb_kd_tree_root_ctrl
// Directed bench for kd_tree_root_ctrl. The bench acts as both the host and a
// stub root node, and drives replies cycle by cycle. Expected values are
// hand-derived from the command/reply timing.
// When KD_CTRL_TIMEOUT_EN is defined, the DUT is built with TIMEOUT=16 and the
// watchdog scenario runs.
`timescale 1ns/1ps
module tb_kd_tree_root_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        center_valid;
  logic        center_ready;
  logic [23:0] center_data;
  logic [1:0]  axis_in;
  logic [4:0]  command_to_root;
  logic [23:0] data_to_root;
  logic [4:0]  command_from_root;
  logic [23:0] data_from_root;
  logic        busy;
  logic        done;
  logic        err;
  logic [2:0]  state_out;
  logic [23:0] root_center;

  int checks = 0;
  int failures = 0;

  logic [23:0] centers [8] = '{24'h010203, 24'h020304, 24'h030405, 24'h040506,
                               24'h050607, 24'h060708, 24'h070809, 24'h080808};

  kd_tree_root_ctrl #(
    .NUM_CENTERS(8),
    .SETTLE_CYCLES(4)
`ifdef KD_CTRL_TIMEOUT_EN
    ,
    .TIMEOUT(16)
`endif
  ) dut (
    .clk(clk), .rst(rst), .start(start),
    .center_valid(center_valid), .center_ready(center_ready), .center_data(center_data),
    .axis_in(axis_in),
    .command_to_root(command_to_root), .data_to_root(data_to_root),
    .command_from_root(command_from_root), .data_from_root(data_from_root),
    .busy(busy), .done(done), .err(err), .state_out(state_out), .root_center(root_center)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Start a run with immediate rst_done and 8 back-to-back beats; ends at FILL entry
  task automatic start_and_load(input logic [1:0] ax);
    start = 1'b1; axis_in = ax; tick(); start = 1'b0; axis_in = 2'd0;
    command_from_root = 5'h1E; tick(); command_from_root = 5'h00;
    for (int i = 0; i < 8; i++) begin
      center_valid = 1'b1; center_data = centers[i]; tick();
    end
    center_valid = 1'b0; center_data = 24'd0;
  endtask

  // Continue from FILL entry with immediate fill/axis completions; ends at SORT entry
  task automatic run_to_sort(input logic [1:0] ax);
    start_and_load(ax);
    command_from_root = 5'h05; tick();
    command_from_root = 5'h07; tick();
    command_from_root = 5'h00;
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; center_valid = 1'b0; center_data = 24'd0; axis_in = 2'd0;
    command_from_root = 5'h00; data_from_root = 24'd0;
    tick(); tick();
    checks++;
    if ({state_out, command_to_root, busy, done, err, center_ready} !== {3'd0, 5'h00, 4'b0000}) begin
      failures++;
      $display("FAIL reset_ctrl: got state=%0d cmd=%h busy=%b done=%b err=%b rdy=%b expected 0 00 0 0 0 0",
               state_out, command_to_root, busy, done, err, center_ready);
    end
    checks++;
    if ({data_to_root, root_center} !== 48'd0) begin
      failures++;
      $display("FAIL reset_data: got data=%h root=%h expected 0 0", data_to_root, root_center);
    end
    rst = 1'b0; tick();
    checks++;
    if (state_out !== 3'd0) begin
      failures++;
      $display("FAIL reset_idle_hold: got state=%0d expected 0", state_out);
    end
  endtask

  // Full run with backpressured LOAD, late replies and steady ready_to_sort
  task automatic test_full_run();
    start = 1'b1; axis_in = 2'd1; tick(); start = 1'b0; axis_in = 2'd0;
    checks++;
    if ({state_out, busy, command_to_root} !== {3'd1, 1'b1, 5'h00}) begin
      failures++;
      $display("FAIL full_enter_rst: got state=%0d busy=%b cmd=%h expected 1 1 00", state_out, busy, command_to_root);
    end
    tick();
    checks++;
    if ({command_to_root, data_to_root} !== {5'h1F, 24'd0}) begin
      failures++;
      $display("FAIL full_cmd_rst: got cmd=%h data=%h expected 1f 000000", command_to_root, data_to_root);
    end
    tick(); tick();
    checks++;
    if (state_out !== 3'd1) begin
      failures++;
      $display("FAIL full_rst_wait: got state=%0d expected 1", state_out);
    end
    command_from_root = 5'h1E; tick(); command_from_root = 5'h00;
    checks++;
    if ({state_out, center_ready} !== {3'd2, 1'b1}) begin
      failures++;
      $display("FAIL full_enter_load: got state=%0d rdy=%b expected 2 1", state_out, center_ready);
    end
    for (int i = 0; i < 8; i++) begin
      center_valid = 1'b1; center_data = centers[i]; tick();
      center_valid = 1'b0; center_data = 24'hFFFFFF;
      if (i < 7) begin
        tick();
        checks++;
        if ({state_out, center_ready} !== {3'd2, 1'b1}) begin
          failures++;
          $display("FAIL full_load_beat%0d: got state=%0d rdy=%b expected 2 1", i, state_out, center_ready);
        end
      end
    end
    checks++;
    if ({state_out, center_ready} !== {3'd3, 1'b0}) begin
      failures++;
      $display("FAIL full_enter_fill: got state=%0d rdy=%b expected 3 0", state_out, center_ready);
    end
    for (int k = 0; k < 10; k++) begin
      tick();
      checks++;
      if ({command_to_root, data_to_root} !== {5'h01, centers[(k < 7) ? k : 7]}) begin
        failures++;
        $display("FAIL full_fill_walk%0d: got cmd=%h data=%h expected 01 %h",
                 k, command_to_root, data_to_root, centers[(k < 7) ? k : 7]);
      end
    end
    command_from_root = 5'h05; tick(); command_from_root = 5'h00;
    checks++;
    if (state_out !== 3'd4) begin
      failures++;
      $display("FAIL full_enter_axis: got state=%0d expected 4", state_out);
    end
    tick();
    checks++;
    if ({command_to_root, data_to_root} !== {5'h02, 24'd1}) begin
      failures++;
      $display("FAIL full_cmd_axis: got cmd=%h data=%h expected 02 000001", command_to_root, data_to_root);
    end
    tick();
    command_from_root = 5'h07; tick();
    command_from_root = 5'h0A; data_from_root = 24'h0A0B0C;
    checks++;
    if (state_out !== 3'd5) begin
      failures++;
      $display("FAIL full_enter_sort: got state=%0d expected 5", state_out);
    end
    for (int j = 0; j < 3; j++) begin
      tick();
      checks++;
      if ({state_out, done, command_to_root, data_to_root} !== {3'd5, 1'b0, 5'h09, 24'd1}) begin
        failures++;
        $display("FAIL full_sort_settle%0d: got state=%0d done=%b cmd=%h data=%h expected 5 0 09 000001",
                 j, state_out, done, command_to_root, data_to_root);
      end
    end
    tick();
    checks++;
    if ({state_out, done, busy, root_center} !== {3'd6, 1'b1, 1'b0, 24'h0A0B0C}) begin
      failures++;
      $display("FAIL full_done: got state=%0d done=%b busy=%b root=%h expected 6 1 0 0a0b0c",
               state_out, done, busy, root_center);
    end
    command_from_root = 5'h00; data_from_root = 24'd0; tick();
    checks++;
    if ({state_out, done, command_to_root, root_center} !== {3'd6, 1'b0, 5'h00, 24'h0A0B0C}) begin
      failures++;
      $display("FAIL full_done_pulse: got state=%0d done=%b cmd=%h root=%h expected 6 0 00 0a0b0c",
               state_out, done, command_to_root, root_center);
    end
  endtask

  // ready_to_sort x3, busy, ready_to_sort x4: only the final streak of 4 settles
  task automatic test_settle_interrupt();
    run_to_sort(2'd2);
    data_from_root = 24'h111111;
    for (int j = 0; j < 3; j++) begin
      command_from_root = 5'h0A; tick();
    end
    command_from_root = 5'h08; tick();
    checks++;
    if ({state_out, done} !== {3'd5, 1'b0}) begin
      failures++;
      $display("FAIL settle_busy_clears: got state=%0d done=%b expected 5 0", state_out, done);
    end
    for (int j = 0; j < 4; j++) begin
      command_from_root = 5'h0A; data_from_root = 24'h0C0D00 + 24'(j); tick();
      checks++;
      if (j < 3) begin
        if ({state_out, done} !== {3'd5, 1'b0}) begin
          failures++;
          $display("FAIL settle_streak%0d: got state=%0d done=%b expected 5 0", j, state_out, done);
        end
      end else begin
        if ({state_out, done, root_center} !== {3'd6, 1'b1, 24'h0C0D03}) begin
          failures++;
          $display("FAIL settle_done: got state=%0d done=%b root=%h expected 6 1 0c0d03",
                   state_out, done, root_center);
        end
      end
    end
    command_from_root = 5'h00; data_from_root = 24'd0;
  endtask

  // center_fill_done while rd_idx=3 skips the remaining centers
  task automatic test_early_fill();
    start_and_load(2'd3);
    tick(); tick(); tick();
    checks++;
    if ({command_to_root, data_to_root} !== {5'h01, centers[2]}) begin
      failures++;
      $display("FAIL early_fill_walk: got cmd=%h data=%h expected 01 %h", command_to_root, data_to_root, centers[2]);
    end
    command_from_root = 5'h05; tick(); command_from_root = 5'h00;
    checks++;
    if ({state_out, data_to_root} !== {3'd4, centers[3]}) begin
      failures++;
      $display("FAIL early_enter_axis: got state=%0d data=%h expected 4 %h", state_out, data_to_root, centers[3]);
    end
    tick();
    checks++;
    if ({command_to_root, data_to_root} !== {5'h02, 24'd3}) begin
      failures++;
      $display("FAIL early_cmd_axis: got cmd=%h data=%h expected 02 000003", command_to_root, data_to_root);
    end
  endtask

  // Start pulse in AXIS is ignored: state holds and the latched axis is kept
  task automatic test_start_while_busy();
    start = 1'b1; axis_in = 2'd0; tick(); start = 1'b0;
    tick();
    checks++;
    if ({state_out, busy, command_to_root, data_to_root} !== {3'd4, 1'b1, 5'h02, 24'd3}) begin
      failures++;
      $display("FAIL busy_start_ignored: got state=%0d busy=%b cmd=%h data=%h expected 4 1 02 000003",
               state_out, busy, command_to_root, data_to_root);
    end
  endtask

  // rst held 2 cycles in the middle of FILL returns to IDLE on the first edge
  task automatic test_reset_mid_fill();
    rst = 1'b1; tick(); rst = 1'b0;
    start_and_load(2'd1);
    tick(); tick();
    checks++;
    if ({state_out, command_to_root} !== {3'd3, 5'h01}) begin
      failures++;
      $display("FAIL midrst_in_fill: got state=%0d cmd=%h expected 3 01", state_out, command_to_root);
    end
    rst = 1'b1; tick();
    checks++;
    if ({state_out, command_to_root, busy, data_to_root} !== {3'd0, 5'h00, 1'b0, 24'd0}) begin
      failures++;
      $display("FAIL midrst_idle: got state=%0d cmd=%h busy=%b data=%h expected 0 00 0 000000",
               state_out, command_to_root, busy, data_to_root);
    end
    tick(); rst = 1'b0; tick();
    checks++;
    if ({state_out, center_ready, done} !== {3'd0, 1'b0, 1'b0}) begin
      failures++;
      $display("FAIL midrst_release: got state=%0d rdy=%b done=%b expected 0 0 0", state_out, center_ready, done);
    end
  endtask

`ifdef KD_CTRL_TIMEOUT_EN
  // No rst_done reply: ERROR after 16 cycles in TREE_RST, start clears err
  task automatic test_timeout();
    start = 1'b1; tick(); start = 1'b0;
    for (int n = 0; n < 15; n++) tick();
    checks++;
    if ({state_out, err} !== {3'd1, 1'b0}) begin
      failures++;
      $display("FAIL tmo_before: got state=%0d err=%b expected 1 0", state_out, err);
    end
    tick();
    checks++;
    if ({state_out, err, busy} !== {3'd7, 1'b1, 1'b0}) begin
      failures++;
      $display("FAIL tmo_error: got state=%0d err=%b busy=%b expected 7 1 0", state_out, err, busy);
    end
    start = 1'b1; tick(); start = 1'b0;
    checks++;
    if ({state_out, err} !== {3'd1, 1'b0}) begin
      failures++;
      $display("FAIL tmo_restart: got state=%0d err=%b expected 1 0", state_out, err);
    end
    rst = 1'b1; tick(); rst = 1'b0;
  endtask
`else
  // Without the watchdog a silent root keeps the sequencer waiting in TREE_RST
  task automatic test_no_timeout();
    start = 1'b1; tick(); start = 1'b0;
    for (int n = 0; n < 40; n++) tick();
    checks++;
    if ({state_out, err, command_to_root} !== {3'd1, 1'b0, 5'h1F}) begin
      failures++;
      $display("FAIL notmo_wait: got state=%0d err=%b cmd=%h expected 1 0 1f", state_out, err, command_to_root);
    end
    rst = 1'b1; tick(); rst = 1'b0;
  endtask
`endif

  initial begin
    test_reset();
    test_full_run();
    test_settle_interrupt();
    test_early_fill();
    test_start_while_busy();
    test_reset_mid_fill();
`ifdef KD_CTRL_TIMEOUT_EN
    test_timeout();
`else
    test_no_timeout();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
